// File: rtl/mux_arb_2x1.sv
// Two-requester arbitrated mux: round-robin on contention, with a per-owner burst cap of
// MAX_HOLD counted beats while the other side is waiting.
module mux_arb_2x1 #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_b,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_out,
  output logic             select
);

  localparam logic [3:0] MaxHold = 4'(MAX_HOLD);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwnA = 2'b01,
    StOwnB = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic       last_a_q, last_a_d;

  logic       beat;
  logic [4:0] hold_inc;
  logic       at_limit;

  // Outputs are decoded from state only, so async reset clears them at once.
  assign gnt_a   = (state_q == StOwnA);
  assign gnt_b   = (state_q == StOwnB);
  assign select  = gnt_a;
  assign m_out   = select ? data_a : data_b;
  assign m_valid = (gnt_a & req_a) | (gnt_b & req_b);

  assign beat     = m_valid & m_ready;
  assign hold_inc = {1'b0, hold_q} + 5'd1;
  // >= rather than == so a saturated owner yields on its next beat once the peer asks.
  assign at_limit = (hold_inc >= {1'b0, MaxHold});

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    last_a_d = last_a_q;

    unique case (state_q)
      StIdle: begin
        if (req_a && (!req_b || !last_a_q)) begin
          state_d = StOwnA;
        end else if (req_b) begin
          state_d = StOwnB;
        end
      end
      StOwnA: begin
        if (!req_a) begin
          state_d = req_b ? StOwnB : StIdle;
        end else if (beat) begin
          if (at_limit && req_b) begin
            state_d = StOwnB;
          end else begin
            hold_d = at_limit ? MaxHold : hold_inc[3:0];
          end
        end
      end
      StOwnB: begin
        if (!req_b) begin
          state_d = req_a ? StOwnA : StIdle;
        end else if (beat) begin
          if (at_limit && req_a) begin
            state_d = StOwnA;
          end else begin
            hold_d = at_limit ? MaxHold : hold_inc[3:0];
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d != state_q) begin
      hold_d = 4'd0;
    end
    if (state_d == StOwnA && state_q != StOwnA) begin
      last_a_d = 1'b1;
    end else if (state_d == StOwnB && state_q != StOwnB) begin
      last_a_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= StIdle;
      hold_q   <= 4'd0;
      last_a_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      last_a_q <= last_a_d;
    end
  end

endmodule

// File: doc/mux_arb_2x1.md
MUX_ARB_2X1 -- requirements
Module: mux_arb_2x1

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of each data path.
REQ-002 SHALL have parameter MAX_HOLD, default 4: maximum consecutive beats one requester may transfer while the other is requesting (legal range 1..15).
REQ-003 SHALL have port clock  input  1  single rising-edge clock.
REQ-004 SHALL have port reset_b  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_a  input  1  requester A wants the shared output; also acts as A's per-beat valid.
REQ-006 SHALL have port data_a  input  WIDTH  requester A data.
REQ-007 SHALL have port gnt_a  output  1  A owns the shared mux.
REQ-008 SHALL have port req_b  input  1  requester B request/valid.
REQ-009 SHALL have port data_b  input  WIDTH  requester B data.
REQ-010 SHALL have port gnt_b  output  1  B owns the shared mux.
REQ-011 SHALL have port m_ready  input  1  downstream accepts the current beat.
REQ-012 SHALL have port m_valid  output  1  m_out carries a valid beat.
REQ-013 SHALL have port m_out  output  WIDTH  shared mux output.
REQ-014 SHALL have port select  output  1  mux select; 1 = A, 0 = B.

Function
REQ-015 SHALL implement a registered FSM with exactly three states: IDLE, OWN_A, OWN_B.
REQ-016 SHALL decode outputs from state: gnt_a = (OWN_A), gnt_b = (OWN_B), select = 1 in OWN_A and 0 otherwise.
REQ-017 SHALL drive m_out = data_a when select = 1, else data_b; this path is combinational.
REQ-018 SHALL drive m_valid = (gnt_a & req_a) | (gnt_b & req_b).
REQ-019 SHALL count a beat only on a cycle with m_valid & m_ready.
REQ-020 SHALL have IDLE grant a single requester on the next edge: req_a alone -> OWN_A; req_b alone -> OWN_B.
REQ-021 SHALL, when req_a and req_b are both high in IDLE, grant the requester that was not the last owner (register last_a); after reset last_a = 0, so A wins first.
REQ-022 SHALL, from OWN_x with req_x low, move to OWN_y if req_y is high, else to IDLE, on the next edge; there is no idle gap between owners.
REQ-023 SHALL keep a hold counter, 4 bits, that clears on every ownership change and increments on each counted beat.
REQ-024 SHALL, from OWN_x when the counted beat brings hold to MAX_HOLD and req_y is high, switch to OWN_y on that edge even if req_x stays high.
REQ-025 SHALL, when req_y is low, let the counter saturate at MAX_HOLD and keep ownership with x for as long as req_x is high.
REQ-026 SHALL, on a forced switch per REQ-024, have the counter restart at 0 for the new owner.
REQ-027 SHALL update last_a on every entry into OWN_A (1) or OWN_B (0).
REQ-028 SHALL only allow the FSM to leave OWN_x when either (a) req_x is low, or (b) the counted beat is the MAX_HOLD-th beat; while m_ready is low, ownership and the counter hold.
REQ-029 SHALL never assert gnt_a and gnt_b together in any cycle.

Reset
REQ-030 SHALL, when reset_b goes low at any time (including mid-burst), immediately force state = IDLE, gnt_a = gnt_b = 0, select = 0, m_valid = 0, hold = 0 and last_a = 0, without waiting for clock.
REQ-031 SHALL, after reset_b deasserts, take the first grant on the first rising edge at which a request is sampled.

Verification
REQ-032 SHALL be verified by this scenario: Single A: req_a = 1, data_a = 8'hA5, m_ready = 1 from IDLE -> gnt_a = 1, select = 1, m_valid = 1, m_out = 8'hA5 one edge later; req_a = 0 -> IDLE next edge.
REQ-033 SHALL be verified by this scenario: Simultaneous after reset: req_a = req_b = 1 in IDLE -> OWN_A first; A drops -> OWN_B the next edge with no IDLE cycle.
REQ-034 SHALL be verified by this scenario: Fairness: both held high, m_ready = 1, MAX_HOLD = 4 -> ownership alternates A,A,A,A,B,B,B,B,A,... in beats, and gnt_a never overlaps gnt_b.
REQ-035 SHALL be verified by this scenario: Backpressure: OWN_A with 3 beats counted, req_b = 1, m_ready = 0 for 5 cycles -> still OWN_A, hold = 3; m_ready = 1 for one cycle -> OWN_B on that edge.
REQ-036 SHALL be verified by this scenario: No contention: req_a held, req_b = 0, 10 beats -> gnt_a stays 1, hold saturates at 4; req_b rises -> switch on the next counted beat.
REQ-037 SHALL be verified by this scenario: Reset mid-burst: OWN_B, reset_b pulsed low between edges -> gnt_b = 0 and m_valid = 0 immediately; after release with both requesting -> OWN_A.
